// File: rtl/inst_fetch_align_pkg.sv
// Shared types and helpers for the instruction fetch/align stage.
// Holds Y86 opcode constants, the length decoder and the fetch FSM states.
package inst_fetch_align_pkg;

    typedef enum logic [1:0] {
        FS_IDLE,
        FS_WAIT,
        FS_DROP
    } fetch_state_e;

    localparam logic [3:0] Y86_OP_HALT   = 4'h0;
    localparam logic [3:0] Y86_OP_NOP    = 4'h1;
    localparam logic [3:0] Y86_OP_RRMOVL = 4'h2;
    localparam logic [3:0] Y86_OP_IRMOVL = 4'h3;
    localparam logic [3:0] Y86_OP_RMMOVL = 4'h4;
    localparam logic [3:0] Y86_OP_MRMOVL = 4'h5;
    localparam logic [3:0] Y86_OP_OPL    = 4'h6;
    localparam logic [3:0] Y86_OP_JXX    = 4'h7;
    localparam logic [3:0] Y86_OP_CALL   = 4'h8;
    localparam logic [3:0] Y86_OP_RET    = 4'h9;
    localparam logic [3:0] Y86_OP_PUSHL  = 4'hA;
    localparam logic [3:0] Y86_OP_POPL   = 4'hB;

    function automatic logic [2:0] y86_inst_len(
        input logic [3:0] op
    );
        logic [2:0] len;
        case (op)
            Y86_OP_HALT,
            Y86_OP_NOP,
            Y86_OP_RET:    len = 3'd1;
            Y86_OP_RRMOVL,
            Y86_OP_OPL,
            Y86_OP_PUSHL,
            Y86_OP_POPL:   len = 3'd2;
            Y86_OP_JXX,
            Y86_OP_CALL:   len = 3'd5;
            Y86_OP_IRMOVL,
            Y86_OP_RMMOVL,
            Y86_OP_MRMOVL: len = 3'd6;
            default:       len = 3'd1;
        endcase
        return len;
    endfunction

endpackage

// File: rtl/inst_fetch_align_fetch_byte_queue.sv
// Byte shift queue: pops from the head, then appends behind the survivors.
// Byte 0 of the storage vector is always the queue head.
module fetch_byte_queue #(
    parameter int BUF_BYTES = 12,
    localparam int CW = $clog2(BUF_BYTES + 1)
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic          flush,
    input  logic [2:0]    pop_cnt,
    input  logic [2:0]    push_cnt,
    input  logic [31:0]   push_data,
    output logic [47:0]   head,
    output logic [CW-1:0] count
);

    logic [BUF_BYTES*8-1:0] data_q;
    logic [BUF_BYTES*8-1:0] data_d;
    logic [CW-1:0]          count_q;
    logic [CW-1:0]          count_d;
    logic [CW-1:0]          base;

    always_comb begin
        base    = count_q - CW'(pop_cnt);
        data_d  = data_q >> {pop_cnt, 3'b000};
        count_d = base + CW'(push_cnt);
        for (int i = 0; i < BUF_BYTES; i++) begin
            for (int j = 0; j < 4; j++) begin
                if (j < int'(push_cnt) &&
                    CW'(i) == base + CW'(j)) begin
                    data_d[i*8 +: 8] = push_data[j*8 +: 8];
                end
            end
        end
        if (flush) begin
            data_d  = '0;
            count_d = '0;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            data_q  <= '0;
            count_q <= '0;
        end else begin
            data_q  <= data_d;
            count_q <= count_d;
        end
    end

    assign head  = data_q[47:0];
    assign count = count_q;

endmodule

// File: rtl/inst_fetch_align.sv
// Instruction fetch and align: word fetches into a byte queue,
// one aligned MIPS/Y86 instruction presented per transfer.
module inst_fetch_align
    import inst_fetch_align_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = 32'h0,
    parameter logic        RESET_MODE = 1'b0,
    parameter int          BUF_BYTES  = 12
) (
    input  logic        clk,
    input  logic        resetn,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_valid,
    input  logic [31:0] imem_rdata,
    output logic        inst_valid,
    output logic [47:0] inst,
    output logic [31:0] inst_pc,
    output logic [31:0] next_inst_pc,
    output logic        mode,
    input  logic        advance,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    input  logic        redirect_mode
);

    localparam int CW = $clog2(BUF_BYTES + 1);

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  fptr_q, fptr_d;
    logic [1:0]   skip_q, skip_d;
    logic         mode_q, mode_d;
    logic         imem_req_q, imem_req_d;
    logic [31:0]  imem_addr_q, imem_addr_d;

    logic [47:0]   head;
    logic [CW-1:0] count;
    logic [2:0]    len;
    logic          valid_w;
    logic          take;
    logic          resp;
    logic [2:0]    pop_cnt;
    logic [2:0]    push_cnt;
    logic [31:0]   push_data;
    logic [47:0]   window;
    int            room;

    always_comb begin
        len = mode_q ? y86_inst_len(head[7:4]) : 3'd4;
        valid_w = (count != '0) && (count >= CW'(len));
        take = advance && valid_w && !redirect;
        resp = imem_valid && (state_q == FS_WAIT) && !redirect;
        pop_cnt = take ? len : 3'd0;
        push_cnt = resp ? (3'd4 - {1'b0, skip_q}) : 3'd0;
        push_data = imem_rdata >> {skip_q, 3'b000};
        window = '0;
        for (int k = 0; k < 6; k++) begin
            if (k < int'(len)) begin
                window[k*8 +: 8] = head[k*8 +: 8];
            end
        end
    end

    fetch_byte_queue #(
        .BUF_BYTES (BUF_BYTES)
    ) u_queue (
        .clk       (clk),
        .resetn    (resetn),
        .flush     (redirect),
        .pop_cnt   (pop_cnt),
        .push_cnt  (push_cnt),
        .push_data (push_data),
        .head      (head),
        .count     (count)
    );

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        fptr_d      = fptr_q;
        skip_d      = skip_q;
        mode_d      = mode_q;
        imem_req_d  = 1'b0;
        imem_addr_d = imem_addr_q;
        room        = int'(count) - int'(pop_cnt);
        if (take) begin
            pc_d = pc_q + 32'(len);
        end
        if (resp) begin
            skip_d  = 2'd0;
            fptr_d  = fptr_q + 32'd4;
            state_d = FS_IDLE;
        end
        if (state_q == FS_DROP && imem_valid) begin
            state_d = FS_IDLE;
        end
        if (redirect) begin
            room   = 0;
            mode_d = redirect_mode;
            fptr_d = {redirect_pc[31:2], 2'b00};
            pc_d   = redirect_mode ? redirect_pc
                                   : fptr_d;
            skip_d = redirect_mode ? redirect_pc[1:0]
                                   : 2'd0;
            // A response landing this cycle retires the old request.
            if (state_q != FS_IDLE) begin
                state_d = imem_valid ? FS_IDLE : FS_DROP;
            end
        end
        if (state_q == FS_IDLE && room + 4 <= BUF_BYTES) begin
            imem_req_d  = 1'b1;
            imem_addr_d = fptr_d;
            state_d     = FS_WAIT;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= FS_IDLE;
            pc_q        <= RESET_PC;
            fptr_q      <= {RESET_PC[31:2], 2'b00};
            skip_q      <= RESET_MODE ? RESET_PC[1:0] : 2'd0;
            mode_q      <= RESET_MODE;
            imem_req_q  <= 1'b0;
            imem_addr_q <= '0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            fptr_q      <= fptr_d;
            skip_q      <= skip_d;
            mode_q      <= mode_d;
            imem_req_q  <= imem_req_d;
            imem_addr_q <= imem_addr_d;
        end
    end

    assign imem_req     = imem_req_q;
    assign imem_addr    = imem_addr_q;
    assign inst_valid   = valid_w;
    assign inst         = valid_w ? window : '0;
    assign inst_pc      = pc_q;
    assign next_inst_pc = valid_w ? pc_q + 32'(len) : '0;
    assign mode         = mode_q;

endmodule

// File: tb/tb_inst_fetch_align.sv
// Directed bench for inst_fetch_align with a latency-programmable
// single-outstanding instruction memory model.
module tb_inst_fetch_align;

    logic        clk;
    logic        resetn;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_valid;
    logic [31:0] imem_rdata;
    logic        inst_valid;
    logic [47:0] inst;
    logic [31:0] inst_pc;
    logic [31:0] next_inst_pc;
    logic        mode;
    logic        advance;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        redirect_mode;

    int checks = 0;
    int errors = 0;

    logic [31:0] mem [0:255];
    int          lat = 1;
    int          cnt = 0;
    bit          pend = 0;
    logic [31:0] paddr = '0;
    int          reqs = 0;

    inst_fetch_align dut (
        .clk           (clk),
        .resetn        (resetn),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_valid    (imem_valid),
        .imem_rdata    (imem_rdata),
        .inst_valid    (inst_valid),
        .inst          (inst),
        .inst_pc       (inst_pc),
        .next_inst_pc  (next_inst_pc),
        .mode          (mode),
        .advance       (advance),
        .redirect      (redirect),
        .redirect_pc   (redirect_pc),
        .redirect_mode (redirect_mode)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            pend       <= 1'b0;
            imem_valid <= 1'b0;
            imem_rdata <= '0;
        end else begin
            imem_valid <= 1'b0;
            if (imem_req) begin
                reqs <= reqs + 1;
                if (lat == 1) begin
                    imem_valid <= 1'b1;
                    imem_rdata <= mem[imem_addr[9:2]];
                end else begin
                    pend  <= 1'b1;
                    cnt   <= lat - 1;
                    paddr <= imem_addr;
                end
            end else if (pend) begin
                if (cnt == 1) begin
                    imem_valid <= 1'b1;
                    imem_rdata <= mem[paddr[9:2]];
                    pend       <= 1'b0;
                end else begin
                    cnt <= cnt - 1;
                end
            end
        end
    end

    task automatic chk(input string tag,
                       input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h",
                   tag, obs, exp);
        end
    endtask

    task automatic redir(input logic [31:0] pc,
                         input logic m);
        redirect      = 1'b1;
        redirect_pc   = pc;
        redirect_mode = m;
        @(negedge clk);
        redirect      = 1'b0;
    endtask

    task automatic take(input string tag,
                        input logic [47:0] ei,
                        input logic [31:0] epc,
                        input logic [31:0] enx);
        int n = 0;
        while (inst_valid !== 1'b1 && n < 60) begin
            @(negedge clk);
            n++;
        end
        chk({tag, ".valid"}, 64'(inst_valid), 64'd1);
        chk({tag, ".inst"}, 64'(inst), 64'(ei));
        chk({tag, ".pc"}, 64'(inst_pc), 64'(epc));
        chk({tag, ".next"}, 64'(next_inst_pc), 64'(enx));
        advance = 1'b1;
        @(negedge clk);
        advance = 1'b0;
    endtask

    task automatic chk_reset_outs(input string tag);
        chk({tag, ".valid"}, 64'(inst_valid), 64'd0);
        chk({tag, ".inst"}, 64'(inst), 64'd0);
        chk({tag, ".pc"}, 64'(inst_pc), 64'd0);
        chk({tag, ".next"}, 64'(next_inst_pc), 64'd0);
        chk({tag, ".mode"}, 64'(mode), 64'd0);
        chk({tag, ".req"}, 64'(imem_req), 64'd0);
        chk({tag, ".addr"}, 64'(imem_addr), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        int r0;
        for (int i = 0; i < 256; i++) mem[i] = '0;
        mem[0]           = 32'h20010005;
        mem[1]           = 32'h20020007;
        mem[4]           = 32'h0A0B0C0D;
        mem[5]           = 32'h01020304;
        mem[6]           = 32'hCAFEF00D;
        mem[7]           = 32'h13579BDF;
        mem[32'h100 >> 2] = 32'h5678F330;
        mem[32'h104 >> 2] = 32'h31601234;
        mem[32'h108 >> 2] = 32'h00000010;
        mem[32'h200 >> 2] = 32'h20CCBBAA;
        mem[32'h204 >> 2] = 32'h00000012;
        mem[32'h300 >> 2] = 32'h30EEDDCC;
        mem[32'h304 >> 2] = 32'h223344F4;
        mem[32'h308 >> 2] = 32'h00000011;

        resetn        = 1'b0;
        advance       = 1'b0;
        redirect      = 1'b0;
        redirect_pc   = '0;
        redirect_mode = 1'b0;
        repeat (2) @(negedge clk);
        chk_reset_outs("rst");
        resetn = 1'b1;

        // MIPS stream from reset
        take("t1.w0", 48'h20010005, 32'h0, 32'h4);
        take("t1.w1", 48'h20020007, 32'h4, 32'h8);

        // Y86 stream with mixed lengths
        redir(32'h100, 1'b1);
        chk("t2.flush", 64'(inst_valid), 64'd0);
        take("t2.irmovl", 48'h12345678F330,
             32'h100, 32'h106);
        take("t2.opl", 48'h3160, 32'h106, 32'h108);
        take("t2.nop", 48'h10, 32'h108, 32'h109);

        // Redirect while a request is in flight
        lat = 3;
        redir(32'h300, 1'b1);
        n = 0;
        while (!(imem_req === 1'b1 &&
                 imem_addr === 32'h300) && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("t3.req300", 64'(imem_req), 64'd1);
        redir(32'h203, 1'b1);
        chk("t3.flush", 64'(inst_valid), 64'd0);
        take("t3.rrmovl", 48'h1220, 32'h203, 32'h205);

        // Six-byte instruction spanning three words
        redir(32'h303, 1'b1);
        take("t3.span", 48'h11223344F430,
             32'h303, 32'h309);

        // Queue saturation with advance low
        lat = 1;
        repeat (30) @(negedge clk);
        r0 = reqs;
        redir(32'h10, 1'b0);
        repeat (30) @(negedge clk);
        chk("t4.reqs", 64'(reqs - r0), 64'd3);
        chk("t4.noreq", 64'(imem_req), 64'd0);
        take("t4.w0", 48'h0A0B0C0D, 32'h10, 32'h14);
        take("t4.w1", 48'h01020304, 32'h14, 32'h18);
        take("t4.w2", 48'hCAFEF00D, 32'h18, 32'h1C);
        take("t4.w3", 48'h13579BDF, 32'h1C, 32'h20);

        // Redirect beats advance and append in one cycle
        redir(32'h0, 1'b0);
        n = 0;
        while (!(imem_valid === 1'b1 &&
                 inst_valid === 1'b1) && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("t5.sync", 64'(imem_valid & inst_valid), 64'd1);
        advance       = 1'b1;
        redirect      = 1'b1;
        redirect_pc   = 32'h204;
        redirect_mode = 1'b1;
        @(negedge clk);
        advance  = 1'b0;
        redirect = 1'b0;
        chk("t5.valid", 64'(inst_valid), 64'd0);
        chk("t5.pc", 64'(inst_pc), 64'h204);
        chk("t5.mode", 64'(mode), 64'd1);
        take("t5.nop", 48'h12, 32'h204, 32'h205);

        // Asynchronous reset mid-stream
        redir(32'h100, 1'b1);
        @(negedge clk);
        #2 resetn = 1'b0;
        #1 chk_reset_outs("t6.rst");
        @(negedge clk);
        resetn = 1'b1;
        take("t6.w0", 48'h20010005, 32'h0, 32'h4);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
